// File: rtl/mem_writeback.sv
// ---------------------------------------------------------------------------
// mem_writeback
//   Memory-access and write-back stage. Accepts one instruction from execute,
//   performs the data-memory transaction for loads/stores, then spends exactly
//   one COMMIT cycle driving the register-file, CPSR or PC write port.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   ex_valid / ex_ready           execute-stage handshake
//   ex_result, ex_cpsr, ex_taken  ALU result, flags word, branch condition
//   ex_rd_num, ex_rd_val, ex_md   destination reg, store data, address/target
//   ex_is_{alu,cmp,jmp,ld,str}    operation class flags (ld>str>alu>cmp>jmp)
//   dmem_req/we/addr/wdata        data-memory request, held until dmem_ack
//   dmem_ack, dmem_rdata          memory completion and load data
//   rf_we/waddr/wdata             register-file write port
//   cpsr_we/cpsr_wdata            CPSR write port
//   pc_we/pc_wdata                PC redirect
//   retired_count                 committed-instruction counter (wraps)
// ---------------------------------------------------------------------------
module mem_writeback #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_cpsr,
    input  logic              ex_taken,
    input  logic [3:0]        ex_rd_num,
    input  logic [DATA_W-1:0] ex_rd_val,
    input  logic [DATA_W-1:0] ex_md,
    input  logic              ex_is_alu,
    input  logic              ex_is_cmp,
    input  logic              ex_is_jmp,
    input  logic              ex_is_ld,
    input  logic              ex_is_str,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              cpsr_we,
    output logic [DATA_W-1:0] cpsr_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wdata,
    output logic [31:0]       retired_count
);

    typedef enum logic [1:0] {IDLE, MEM, COMMIT} state_t;
    typedef enum logic [2:0] {CLS_NONE, CLS_LD, CLS_STR, CLS_ALU, CLS_CMP, CLS_JMP} cls_t;

    state_t state_q, state_d;
    cls_t   cls_d, cls_p1;

    logic [DATA_W-1:0] result_p1;
    logic [DATA_W-1:0] cpsr_p1;
    logic              taken_p1;
    logic [3:0]        rd_num_p1;
    logic [DATA_W-1:0] rd_val_p1;
    logic [DATA_W-1:0] md_p1;
    logic [DATA_W-1:0] ld_data_p2;
    logic [31:0]       retired_cnt;
    logic              accept;

    // Ready depends on state only, so execute never sees a combinational
    // path from dmem_ack or ex_valid back into ex_ready.
    assign ex_ready      = (state_q != MEM);
    assign accept        = ex_valid && ex_ready;
    assign retired_count = retired_cnt;

    // Only the highest-priority class survives capture.
    always_comb begin
        cls_d = CLS_NONE;
        if      (ex_is_ld)  cls_d = CLS_LD;
        else if (ex_is_str) cls_d = CLS_STR;
        else if (ex_is_alu) cls_d = CLS_ALU;
        else if (ex_is_cmp) cls_d = CLS_CMP;
        else if (ex_is_jmp) cls_d = CLS_JMP;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COMMIT: begin
                if (accept)
                    state_d = (cls_d == CLS_LD || cls_d == CLS_STR) ? MEM : COMMIT;
                else
                    state_d = IDLE;
            end
            MEM:     if (dmem_ack) state_d = COMMIT;
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, captured class and retire counter.
    // The counter advances on the edge entering COMMIT so it already
    // reflects the instruction during its commit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cls_p1      <= CLS_NONE;
            retired_cnt <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept)
                cls_p1 <= cls_d;
            if (state_d == COMMIT)
                retired_cnt <= retired_cnt + 32'd1;
        end
    end

    // Stage p1: instruction fields captured on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            result_p1 <= ex_result;
            cpsr_p1   <= ex_cpsr;
            taken_p1  <= ex_taken;
            rd_num_p1 <= ex_rd_num;
            rd_val_p1 <= ex_rd_val;
            md_p1     <= ex_md;
        end
    end

    // Stage p2: load data captured on the ack edge
    always_ff @(posedge clk) begin
        if (state_q == MEM && dmem_ack && cls_p1 == CLS_LD)
            ld_data_p2 <= dmem_rdata;
    end

    // Outputs are decoded from state and captured fields only. Data/address
    // outputs are forced to zero whenever their strobe is inactive, which
    // keeps them X-free and zero through reset.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        rf_we      = 1'b0;
        rf_waddr   = 4'd0;
        rf_wdata   = '0;
        cpsr_we    = 1'b0;
        cpsr_wdata = '0;
        pc_we      = 1'b0;
        pc_wdata   = '0;
        if (state_q == MEM) begin
            dmem_req  = 1'b1;
            dmem_we   = (cls_p1 == CLS_STR);
            dmem_addr = md_p1;
            if (cls_p1 == CLS_STR)
                dmem_wdata = rd_val_p1;
        end else if (state_q == COMMIT) begin
            case (cls_p1)
                CLS_ALU: begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_num_p1;
                    rf_wdata = result_p1;
                end
                CLS_LD: begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_num_p1;
                    rf_wdata = ld_data_p2;
                end
                CLS_CMP: begin
                    cpsr_we    = 1'b1;
                    cpsr_wdata = cpsr_p1;
                end
                CLS_JMP: begin
                    if (taken_p1) begin
                        pc_we    = 1'b1;
                        pc_wdata = md_p1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
